mips_multicycle_ctrl: RTL and testbench

Multi-cycle main controller for the MIPS32 datapath: a Moore state machine that sequences fetch, decode, execute, memory and write-back over several clocks, reusing one ALU and one memory port. It replaces per-opcode static decode with per-state control, and stalls on a memory ready handshake. It sits beside the datapath, takes the opcode from the held instruction register and the ALU zero flag, and drives every datapath enable and mux select.

---
 rtl/mips_ctrl_pkg.sv | 59 +++++
 rtl/mips_ctrl_decode.sv | 87 ++++++++
 rtl/mips_multicycle_ctrl.sv | 134 +++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multi-cycle controller: states, opcodes and mux selects.
// The ADDIEX/ADDIWB state codes are reserved in every build so other encodings never shift.
package mips_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE   = 4'd0;
    localparam state_t ST_FETCH  = 4'd1;
    localparam state_t ST_DECODE = 4'd2;
    localparam state_t ST_MEMADR = 4'd3;
    localparam state_t ST_MEMRD  = 4'd4;
    localparam state_t ST_MEMWB  = 4'd5;
    localparam state_t ST_MEMWR  = 4'd6;
    localparam state_t ST_EXEC   = 4'd7;
    localparam state_t ST_RWB    = 4'd8;
    localparam state_t ST_BRANCH = 4'd9;
    localparam state_t ST_JUMP   = 4'd10;
    localparam state_t ST_ADDIEX = 4'd11;
    localparam state_t ST_ADDIWB = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'(16'h0000);

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational per-state control decode; the only input-dependent terms are the
// FETCH-stage IR/PC loads, which follow mem_ready. ADDI_EN enables the addi states.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // Moore control word for the current state; unlisted fields stay zero
    always_comb begin
        ctrl = CTRL_NONE;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SL2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.branch    = 1'b1;
                ctrl.pc_source = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef ADDI_EN
            ST_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
`endif
            default: begin
                ctrl = CTRL_NONE;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// MIPS32 multi-cycle main controller: state register, next-state logic and sticky illegal flag.
// Define ADDI_EN to support addi (0x08) through the ADDIEX/ADDIWB states; otherwise it is illegal.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       branch,
    output logic       pc_en,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       regdst,
    output logic       regWrite,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] AluOp,
    output logic [1:0] PCSource,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    ctrl_t  ctrl_s;

    mips_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_s)
    );

    // Next-state and sticky illegal-opcode logic
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
`ifdef ADDI_EN
                    OP_ADDI:      state_d = ST_ADDIEX;
`endif
                    default: begin
                        state_d   = ST_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: begin
                // Opcode is held in the IR, so only lw/sw can arrive here
                if (opcode == OP_LW) begin
                    state_d = ST_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = ST_MEMWR;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEMRD: begin
                if (mem_ready) begin
                    state_d = ST_MEMWB;
                end else begin
                    state_d = ST_MEMRD;
                end
            end
            ST_MEMWR: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_MEMWR;
                end
            end
            ST_EXEC:   state_d = ST_RWB;
            ST_MEMWB,
            ST_RWB,
            ST_BRANCH,
            ST_JUMP:   state_d = ST_FETCH;
`ifdef ADDI_EN
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_ADDIWB: state_d = ST_FETCH;
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    // State and illegal flag registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign PCWrite  = ctrl_s.pc_write;
    assign branch   = ctrl_s.branch;
    assign pc_en    = ctrl_s.pc_write | (ctrl_s.branch & zero);
    assign IorD     = ctrl_s.iord;
    assign MemRead  = ctrl_s.mem_read;
    assign MemWrite = ctrl_s.mem_write;
    assign IRWrite  = ctrl_s.ir_write;
    assign MemtoReg = ctrl_s.mem_to_reg;
    assign regdst   = ctrl_s.reg_dst;
    assign regWrite = ctrl_s.reg_write;
    assign AluSrcA  = ctrl_s.alu_src_a;
    assign AluSrcB  = ctrl_s.alu_src_b;
    assign AluOp    = ctrl_s.alu_op;
    assign PCSource = ctrl_s.pc_source;
    assign illegal  = illegal_q;
    assign state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for mips_multicycle_ctrl plus hand sequences for reset and addi.
module tb_mips_multicycle_ctrl;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_RWB    = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_ADDIEX = 4'd11;
    localparam logic [3:0] S_ADDIWB = 4'd12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, branch, pc_en, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, regdst, regWrite, AluSrcA, illegal;
    logic [1:0] AluSrcB, AluOp, PCSource;
    logic [3:0] state;

    int passed = 0;
    int total  = 0;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .branch(branch), .pc_en(pc_en), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .regdst(regdst), .regWrite(regWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
        .AluOp(AluOp), .PCSource(PCSource), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] outs;
    } vec_t;

    vec_t tbl[27];

    // Output bundle order: PCWrite branch pc_en IorD MemRead MemWrite IRWrite MemtoReg
    // regdst regWrite AluSrcA AluSrcB AluOp PCSource illegal
    function automatic logic [17:0] mk(input logic pcw, input logic br, input logic pce,
                                       input logic iord, input logic mrd, input logic mwr,
                                       input logic irw, input logic m2r, input logic rd,
                                       input logic rw, input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic [1:0] pcs,
                                       input logic ill);
        return {pcw, br, pce, iord, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
    endfunction

    function automatic logic [17:0] outs_now();
        return {PCWrite, branch, pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                regdst, regWrite, AluSrcA, AluSrcB, AluOp, PCSource, illegal};
    endfunction

    task automatic check(input int tag, input string what, input logic [17:0] got,
                         input logic [17:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s #%0d: got %05h want %05h", what, tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic step(input int tag, input logic [5:0] op, input logic z, input logic mr,
                        input logic [3:0] est, input logic [17:0] eouts);
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        #1;
        check(tag, "state", {14'd0, state}, {14'd0, est});
        check(tag, "outs", outs_now(), eouts);
        @(negedge clk);
    endtask

    logic [17:0] o_zero, o_fetch, o_fetch_w, o_dec, o_madr, o_mrd, o_mwb, o_mwr;
    logic [17:0] o_exec, o_rwb, o_br1, o_br0, o_jump, o_aex, o_awb, o_ill;

    initial begin
        o_zero    = mk(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        o_fetch   = mk(1,0,1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
        o_fetch_w = mk(0,0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
        o_dec     = mk(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
        o_madr    = mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        o_mrd     = mk(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        o_mwb     = mk(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
        o_mwr     = mk(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        o_exec    = mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
        o_rwb     = mk(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
        o_br1     = mk(0,1,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
        o_br0     = mk(0,1,0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
        o_jump    = mk(1,0,1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);
        o_aex     = mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        o_awb     = mk(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
        o_ill     = 18'h00001;

        // R-type; then lw with two MEMRD wait cycles; beq taken / not taken; sw with fetch wait; j
        tbl[0]  = '{6'h00, 1'b0, 1'b1, S_IDLE,   o_zero};
        tbl[1]  = '{6'h00, 1'b0, 1'b1, S_FETCH,  o_fetch};
        tbl[2]  = '{6'h00, 1'b0, 1'b0, S_DECODE, o_dec};
        tbl[3]  = '{6'h00, 1'b0, 1'b0, S_EXEC,   o_exec};
        tbl[4]  = '{6'h00, 1'b0, 1'b1, S_RWB,    o_rwb};
        tbl[5]  = '{6'h23, 1'b0, 1'b1, S_FETCH,  o_fetch};
        tbl[6]  = '{6'h23, 1'b0, 1'b1, S_DECODE, o_dec};
        tbl[7]  = '{6'h23, 1'b0, 1'b0, S_MEMADR, o_madr};
        tbl[8]  = '{6'h23, 1'b0, 1'b0, S_MEMRD,  o_mrd};
        tbl[9]  = '{6'h23, 1'b0, 1'b0, S_MEMRD,  o_mrd};
        tbl[10] = '{6'h23, 1'b0, 1'b1, S_MEMRD,  o_mrd};
        tbl[11] = '{6'h23, 1'b0, 1'b0, S_MEMWB,  o_mwb};
        tbl[12] = '{6'h04, 1'b1, 1'b1, S_FETCH,  o_fetch};
        tbl[13] = '{6'h04, 1'b1, 1'b1, S_DECODE, o_dec};
        tbl[14] = '{6'h04, 1'b1, 1'b0, S_BRANCH, o_br1};
        tbl[15] = '{6'h04, 1'b0, 1'b1, S_FETCH,  o_fetch};
        tbl[16] = '{6'h04, 1'b0, 1'b1, S_DECODE, o_dec};
        tbl[17] = '{6'h04, 1'b0, 1'b1, S_BRANCH, o_br0};
        tbl[18] = '{6'h2B, 1'b0, 1'b0, S_FETCH,  o_fetch_w};
        tbl[19] = '{6'h2B, 1'b0, 1'b1, S_FETCH,  o_fetch};
        tbl[20] = '{6'h2B, 1'b0, 1'b0, S_DECODE, o_dec};
        tbl[21] = '{6'h2B, 1'b0, 1'b1, S_MEMADR, o_madr};
        tbl[22] = '{6'h2B, 1'b0, 1'b0, S_MEMWR,  o_mwr};
        tbl[23] = '{6'h2B, 1'b0, 1'b1, S_MEMWR,  o_mwr};
        tbl[24] = '{6'h02, 1'b0, 1'b1, S_FETCH,  o_fetch};
        tbl[25] = '{6'h02, 1'b0, 1'b1, S_DECODE, o_dec};
        tbl[26] = '{6'h02, 1'b0, 1'b1, S_JUMP,   o_jump};

        rst_n     = 1'b0;
        opcode    = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check(0, "reset_state", {14'd0, state}, {14'd0, S_IDLE});
        check(0, "reset_outs", outs_now(), o_zero);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            step(i, tbl[i].op, tbl[i].z, tbl[i].mr, tbl[i].st, tbl[i].outs);
        end

        // Illegal opcode: flag rises after DECODE and survives an R-type and a second illegal
        step(100, 6'h3F, 1'b0, 1'b1, S_FETCH,  o_fetch);
        step(101, 6'h3F, 1'b0, 1'b1, S_DECODE, o_dec);
        step(102, 6'h00, 1'b0, 1'b1, S_FETCH,  o_fetch | o_ill);
        step(103, 6'h00, 1'b0, 1'b1, S_DECODE, o_dec   | o_ill);
        step(104, 6'h00, 1'b0, 1'b1, S_EXEC,   o_exec  | o_ill);
        step(105, 6'h00, 1'b0, 1'b1, S_RWB,    o_rwb   | o_ill);
        step(106, 6'h3F, 1'b0, 1'b1, S_FETCH,  o_fetch | o_ill);
        step(107, 6'h3F, 1'b0, 1'b1, S_DECODE, o_dec   | o_ill);
        opcode = 6'h00;
        #1;
        check(108, "ill_sticky", outs_now(), o_fetch | o_ill);
        rst_n = 1'b0;
        #1;
        check(109, "ill_rst_state", {14'd0, state}, {14'd0, S_IDLE});
        check(109, "ill_rst_outs", outs_now(), o_zero);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during a stalled store drops MemWrite without a clock edge
        step(110, 6'h2B, 1'b0, 1'b1, S_IDLE,   o_zero);
        step(111, 6'h2B, 1'b0, 1'b1, S_FETCH,  o_fetch);
        step(112, 6'h2B, 1'b0, 1'b1, S_DECODE, o_dec);
        step(113, 6'h2B, 1'b0, 1'b1, S_MEMADR, o_madr);
        mem_ready = 1'b0;
        #1;
        check(114, "memwr_state", {14'd0, state}, {14'd0, S_MEMWR});
        check(114, "memwr_outs", outs_now(), o_mwr);
        #2;
        rst_n = 1'b0;
        #1;
        check(115, "memwr_rst_state", {14'd0, state}, {14'd0, S_IDLE});
        check(115, "memwr_rst_outs", outs_now(), o_zero);
        @(negedge clk);
        rst_n = 1'b1;

        // addi: two extra states when enabled, otherwise a 2-clock illegal trip
        step(116, 6'h08, 1'b0, 1'b1, S_IDLE,   o_zero);
        step(117, 6'h08, 1'b0, 1'b1, S_FETCH,  o_fetch);
        step(118, 6'h08, 1'b0, 1'b1, S_DECODE, o_dec);
`ifdef ADDI_EN
        step(119, 6'h08, 1'b0, 1'b1, S_ADDIEX, o_aex);
        step(120, 6'h08, 1'b0, 1'b1, S_ADDIWB, o_awb);
        step(121, 6'h00, 1'b0, 1'b1, S_FETCH,  o_fetch);
`else
        step(119, 6'h00, 1'b0, 1'b1, S_FETCH,  o_fetch | o_ill);
        step(120, 6'h00, 1'b0, 1'b1, S_DECODE, o_dec   | o_ill);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
